multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath: a Moore FSM that drives the shared ALU, register file, PC and unified memory across several clock cycles per instruction, replacing the single-cycle combinational control. It sits between the instruction register opcode and all datapath mux/enable signals. It also handles a ready handshake with a variable-latency unified instruction/data memory.

## Interface
- No parameters. Opcode, state and ALUOp encodings come from the shared package.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- Opcode  in  6  IR[31:26].
- Zero  in  1  ALU zero flag, sampled in BRANCH.
- MemReady  in  1  memory completed the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath enables and selects.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  one-cycle pulse on an unknown opcode.
- State  out  4  current state, for debug.
- InstrCount  out  32  number of instructions retired.

## Operation
- States: RESET, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH, JUMP.
- RESET:
  - Entered asynchronously while Reset = 0.
  - All outputs 0; InstrCount = 0.
  - After Reset rises, the FSM moves to FETCH on the next rising edge.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Stays in FETCH while MemReady = 0.
  - On the cycle MemReady = 1: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE:
  - Computes the branch target: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Opcode: 000000 → EXECUTE; 100011 (lw) or 101011 (sw) → MEMADDR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDIEXEC.
  - Any other opcode → Illegal=1 for that cycle, then FETCH. InstrCount is not incremented.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Held until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, then FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Held until MemReady=1, then FETCH.
- EXECUTE → ALUWB:
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
- ADDIEXEC → ADDIWB:
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- Any signal not listed for a state is 0 in that state.
- InstrCount increments by 1 on each transition into FETCH from a terminal state (MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP). It wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are decoded from the registered state only. Exception: IRWrite/PCWrite in FETCH and the MEMREAD/MEMWRITE exits are gated by MemReady.
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead and MemWrite stay stable while waiting and drop on the cycle after MemReady=1.
- MemReady is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction:
  - Immediately forces RESET and zeroes all outputs, including an in-progress MemWrite.
  - No partial write-back happens on the next edge.
- Opcode is sampled only in DECODE and MEMADDR. The IR is stable after FETCH.

## Structure
- Package mc_pkg holds:
  - 4-bit state localparams (RESET=0, FETCH=1, …);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp codes.
- One natural sub-module: mc_output_decode, a combinational state → control-word decoder.
- The top module keeps the state register, next-state logic and InstrCount.

## Test plan
- Reset low 2 cycles, then high: State=RESET with all outputs 0. Next edge State=FETCH with MemRead=1, ALUSrcB=01.
- R-type (Opcode=000000), MemReady tied 1: FETCH→DECODE→EXECUTE→ALUWB→FETCH in 4 cycles. RegWrite=1 and RegDst=1 only in ALUWB. InstrCount 0→1.
- lw with MemReady low for 3 cycles in MEMREAD: MemRead=1, IorD=1 held 4 cycles. Total 8 cycles. MEMWB asserts RegWrite=1, MemtoReg=1.
- beq with Zero=1, then again with Zero=0: both take 3 cycles with PCWriteCond=1, PCSource=01 in BRANCH. InstrCount advances by 2.
- Opcode=111111: Illegal pulses 1 cycle in DECODE, then FETCH. InstrCount unchanged.
- sw stalled in MEMWRITE, Reset pulled low mid-wait: MemWrite drops to 0 asynchronously. State=RESET, InstrCount=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU/mux select codes and the control word passed from decoder to top.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADDR  = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXECUTE  = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_known_op = 1'b1;
      default:                                       is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word decoder. Only FETCH handshake strobes
// and the DECODE illegal flag look at anything besides the state.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH2;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.illegal   = ~is_known_op(opcode_i);
      end
      ST_MEMADDR, ST_ADDIEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: state register, next-state logic and the
// retired-instruction counter; outputs come from mc_output_decode.
module multicycle_control
  import mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] instr_count_o
);

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire_s;
  ctrl_t       ctrl_s;
  // Zero is consumed by the datapath's branch gate, not by the sequencer.
  logic        unused_zero_s;

  assign unused_zero_s = zero_i;

  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready_i) state_d = ST_DECODE;
        else             state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_LW, OP_SW: state_d = ST_MEMADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADDR: begin
        if (opcode_i == OP_SW) state_d = ST_MEMWRITE;
        else                   state_d = ST_MEMREAD;
      end
      ST_MEMREAD: begin
        if (mem_ready_i) state_d = ST_MEMWB;
        else             state_d = ST_MEMREAD;
      end
      ST_MEMWRITE: begin
        if (mem_ready_i) begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = ST_MEMWRITE;
        end
      end
      ST_EXECUTE:  state_d = ST_ALUWB;
      ST_ADDIEXEC: state_d = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign instr_count_d = retire_s ? instr_count_q + 32'd1 : instr_count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_RESET;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl_s)
  );

  assign pc_write_o      = ctrl_s.pc_write;
  assign pc_write_cond_o = ctrl_s.pc_write_cond;
  assign iord_o          = ctrl_s.iord;
  assign mem_read_o      = ctrl_s.mem_read;
  assign mem_write_o     = ctrl_s.mem_write;
  assign ir_write_o      = ctrl_s.ir_write;
  assign mem_to_reg_o    = ctrl_s.mem_to_reg;
  assign reg_dst_o       = ctrl_s.reg_dst;
  assign reg_write_o     = ctrl_s.reg_write;
  assign alu_src_a_o     = ctrl_s.alu_src_a;
  assign alu_src_b_o     = ctrl_s.alu_src_b;
  assign alu_op_o        = ctrl_s.alu_op;
  assign pc_source_o     = ctrl_s.pc_source;
  assign illegal_o       = ctrl_s.illegal;
  assign state_o         = state_q;
  assign instr_count_o   = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed plan items then random instruction
// streams, each cycle's control word predicted from the instruction type.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero, mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_count = 32'd0;
  int          cyc;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .zero_i(zero),
    .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .iord_o(iord),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .illegal_o(illegal), .state_o(state),
    .instr_count_o(instr_count)
  );

  // enables packed as {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA}
  function automatic logic [20:0] observed();
    return {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal};
  endfunction

  // One cycle: drive MemReady, compare the whole control word, advance to next negedge.
  task automatic step(input logic rdy, input logic [3:0] st, input logic [9:0] en,
                      input logic [1:0] srcb, input logic [1:0] aop,
                      input logic [1:0] pcs, input logic ill, input string tag);
    logic [20:0] exp_w, obs_w;
    mem_ready = rdy;
    #1;
    exp_w = {st, en, srcb, aop, pcs, ill};
    obs_w = observed();
    total++;
    assert (obs_w === exp_w) else begin
      bad++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs_w, exp_w);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_count(input string tag);
    total++;
    assert (instr_count === model_count) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, instr_count, model_count);
    end
  endtask

  task automatic fetch(input int stalls);
    for (int i = 0; i < stalls; i++)
      step(1'b0, 4'd1, 10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, "fetch_wait");
    step(1'b1, 4'd1, 10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, "fetch_done");
  endtask

  // Full instruction from FETCH back to the next FETCH, updating the retired model.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input logic z);
    logic known;
    known = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    opcode = op;
    zero   = z;
    check_count("count_before");
    fetch(fstall);
    step(1'($urandom), 4'd2, 10'b0, 2'b11, 2'b00, 2'b00, ~known, "decode");
    case (op)
      6'b000000: begin
        step(1'($urandom), 4'd7, 10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, "execute");
        step(1'($urandom), 4'd8, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0, "aluwb");
      end
      6'b001000: begin
        step(1'($urandom), 4'd9, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, "addiexec");
        step(1'($urandom), 4'd10, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0, "addiwb");
      end
      6'b100011: begin
        step(1'($urandom), 4'd3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, "memaddr");
        for (int i = 0; i < mstall; i++)
          step(1'b0, 4'd4, 10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, "memread_wait");
        step(1'b1, 4'd4, 10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, "memread_done");
        step(1'($urandom), 4'd5, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0, "memwb");
      end
      6'b101011: begin
        step(1'($urandom), 4'd3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, "memaddr");
        for (int i = 0; i < mstall; i++)
          step(1'b0, 4'd6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, "memwrite_wait");
        step(1'b1, 4'd6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, "memwrite_done");
      end
      6'b000100:
        step(1'($urandom), 4'd11, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0, "branch");
      6'b000010:
        step(1'($urandom), 4'd12, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0, "jump");
      default: ;
    endcase
    if (known) model_count = model_count + 32'd1;
    check_count("count_after");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_count = 32'd0;
    step(1'b1, 4'd0, 10'b0, 2'b00, 2'b00, 2'b00, 1'b0, "in_reset");
    rst_n = 1'b1;
    step(1'b1, 4'd0, 10'b0, 2'b00, 2'b00, 2'b00, 1'b0, "reset_released");
    check_count("count_reset");
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int         start;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    cyc = 0;
    opcode = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    start = cyc;
    run_instr(6'b000000, 0, 0, 1'b0);
    total++;
    assert (cyc - start == 4) else begin
      bad++; $error("FAIL rtype_cycles: observed=%0d expected=4", cyc - start);
    end
    start = cyc;
    run_instr(6'b100011, 0, 3, 1'b0);
    total++;
    assert (cyc - start == 8) else begin
      bad++; $error("FAIL lw_cycles: observed=%0d expected=8", cyc - start);
    end
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b101011, 2, 0, 1'b0);
    run_instr(6'b001000, 0, 0, 1'b0);
    run_instr(6'b000010, 1, 0, 1'b0);

    // sw stalled in MEMWRITE, reset pulled mid-wait
    opcode = 6'b101011;
    fetch(0);
    step(1'b0, 4'd2, 10'b0, 2'b11, 2'b00, 2'b00, 1'b0, "decode_sw");
    step(1'b0, 4'd3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, "memaddr_sw");
    step(1'b0, 4'd6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, "memwrite_wait");
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_count = 32'd0;
    total++;
    assert ({mem_write, state} === 5'b0_0000) else begin
      bad++; $error("FAIL async_reset: observed=%b expected=00000", {mem_write, state});
    end
    check_count("count_async_reset");
    @(negedge clk);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do begin
          op = 6'($urandom);
        end while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                   op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
